// File: rtl/ram_arbiter.sv
// ram_arbiter: two-client round-robin sequencer for the shared 37-bit log RAM.
// Serialises single-word reads/writes from clients A and B, issues the
// one-cycle RAM clear on request, and rejects out-of-range addresses.
// Ports:
//   clk, rst_n (sync, active low)
//   a_req/a_we/a_addr/a_wdata -> a_ack/a_err/a_rdata   (client A)
//   b_req/b_we/b_addr/b_wdata -> b_ack/b_err/b_rdata   (client B)
//   clr_req -> clr_ack ; busy
//   ram_clr/ram_we/ram_re/ram_wr_addr/ram_rd_addr/ram_wr_data, ram_rd_data
// Optional feature macro: RAM_ARB_WPROT_EN (client B writes below PROT_TOP
// are rejected when defined).
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 37,
    parameter int DEPTH      = ADDR_WIDTH ** 2,
    parameter int PROT_TOP   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic                  a_err,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  clr_req,
    output logic                  clr_ack,
    output logic                  busy,
    output logic                  ram_clr,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    typedef enum logic [2:0] {
        IDLE, WR, RD0, RD1, CLR, DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PROT_W  = (ADDR_WIDTH+1)'(PROT_TOP);

`ifdef RAM_ARB_WPROT_EN
    localparam bit WPROT_EN = 1'b1;
`else
    localparam bit WPROT_EN = 1'b0;
`endif

    state_t state, state_nx;

    // last_grant/gnt: 0 = client A, 1 = client B
    logic                  last_grant;
    logic                  gnt;
    logic                  err_q;
    logic                  clr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  pick_b;
    logic                  any_req;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  reject;

    // On a tie the client that did not win last time gets the grant.
    always_comb begin
        any_req = a_req | b_req;
        pick_b  = 1'b0;
        if (a_req && b_req)
            pick_b = ~last_grant;
        else
            pick_b = b_req;
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
        reject    = ({1'b0, sel_addr} >= DEPTH_W)
                  | (WPROT_EN & pick_b & sel_we
                     & ({1'b0, sel_addr} < PROT_W));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (clr_req)
                    state_nx = CLR;
                else if (any_req)
                    state_nx = reject ? DONE : (sel_we ? WR : RD0);
            end
            WR:      state_nx = DONE;
            RD0:     state_nx = RD1;
            RD1:     state_nx = DONE;
            CLR:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, grant history and read-data capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            err_q      <= 1'b0;
            clr_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            if (state == IDLE) begin
                if (clr_req) begin
                    clr_q <= 1'b1;
                    err_q <= 1'b0;
                end else if (any_req) begin
                    clr_q      <= 1'b0;
                    gnt        <= pick_b;
                    last_grant <= pick_b;
                    addr_q     <= sel_addr;
                    wdata_q    <= sel_wdata;
                    err_q      <= reject;
                end
            end
            if (state == RD1) begin
                if (gnt)
                    b_rdata <= ram_rd_data;
                else
                    a_rdata <= ram_rd_data;
            end
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy        = (state != IDLE);
        ram_we      = (state == WR);
        ram_re      = (state == RD0) || (state == RD1);
        ram_clr     = (state == CLR);
        clr_ack     = (state == DONE) && clr_q;
        a_ack       = (state == DONE) && !clr_q && !gnt;
        b_ack       = (state == DONE) && !clr_q && gnt;
        a_err       = a_ack && err_q;
        b_err       = b_ack && err_q;
        ram_wr_addr = addr_q;
        ram_rd_addr = addr_q;
        ram_wr_data = wdata_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// behavioural model of the registered-read log RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we, clr_req;
    logic [7:0]  a_addr, b_addr;
    logic [36:0] a_wdata, b_wdata;
    logic        a_ack, a_err, b_ack, b_err, clr_ack, busy;
    logic [36:0] a_rdata, b_rdata;
    logic        ram_clr, ram_we, ram_re;
    logic [7:0]  ram_wr_addr, ram_rd_addr;
    logic [36:0] ram_wr_data, ram_rd_data;

    int vectors = 0;
    int miscompares = 0;

    logic [36:0] mem [0:255];
    logic [36:0] rd_q;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .clr_req(clr_req), .clr_ack(clr_ack), .busy(busy),
        .ram_clr(ram_clr), .ram_we(ram_we), .ram_re(ram_re),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    // RAM model: clear, single write port, registered read, output enable = re
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rd_q = '0;
    end

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ram_we) begin
            mem[ram_wr_addr] <= ram_wr_data;
        end
        if (ram_re) rd_q <= mem[ram_rd_addr];
    end

    assign ram_rd_data = ram_re ? rd_q : '0;

    task automatic run_txn(input bit cl, input bit we, input logic [7:0] addr,
                           input logic [36:0] wdata, input int exp_lat,
                           input bit exp_err, input bit chk_rd,
                           input logic [36:0] exp_rd, input string tag);
        int n = 0, re_cnt = 0, we_cnt = 0;
        bit got = 0, other = 0, err = 0;
        logic [36:0] rd;
        if (cl) begin
            b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ram_re) re_cnt++;
            if (ram_we) we_cnt++;
            if (cl ? a_ack : b_ack) other = 1;
            if (cl ? b_ack : a_ack) begin
                got = 1;
                err = cl ? b_err : a_err;
            end
        end
        a_req = 0; b_req = 0;
        vectors++;
        if (!got || n !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d (acked=%0d) expected %0d",
                     tag, n, got, exp_lat);
        end
        vectors++;
        if (err !== exp_err) begin
            miscompares++;
            $display("FAIL %s err: got %0d expected %0d", tag, err, exp_err);
        end
        vectors++;
        if (we_cnt !== ((we && !exp_err) ? 1 : 0) ||
            re_cnt !== ((!we && !exp_err) ? 2 : 0)) begin
            miscompares++;
            $display("FAIL %s ram strobes: we=%0d re=%0d", tag, we_cnt, re_cnt);
        end
        vectors++;
        if (other) begin
            miscompares++;
            $display("FAIL %s wrong client acked: got 1 expected 0", tag);
        end
        if (chk_rd) begin
            rd = cl ? b_rdata : a_rdata;
            vectors++;
            if (rd !== exp_rd) begin
                miscompares++;
                $display("FAIL %s rdata: got %h expected %h", tag, rd, exp_rd);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        clr_req = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({busy, a_ack, a_err, b_ack, b_err, clr_ack,
             ram_clr, ram_we, ram_re} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset ctrl outputs: got %b expected 0",
                     {busy, a_ack, a_err, b_ack, b_err, clr_ack,
                      ram_clr, ram_we, ram_re});
        end
        vectors++;
        if (a_rdata !== 0 || b_rdata !== 0 || ram_wr_addr !== 0 ||
            ram_rd_addr !== 0 || ram_wr_data !== 0) begin
            miscompares++;
            $display("FAIL reset data outputs: got %h %h %h expected 0",
                     a_rdata, b_rdata, ram_wr_data);
        end
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int order [4];
        int k = 0, cyc = 0;
        bit both = 0;
        a_req = 1; a_we = 1; a_addr = 8'd10; a_wdata = 37'h0_0000_00aa;
        b_req = 1; b_we = 1; b_addr = 8'd11; b_wdata = 37'h0_0000_00bb;
        while (k < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (a_ack && b_ack) both = 1;
            if (a_ack) begin order[k] = 0; k++; end
            else if (b_ack) begin order[k] = 1; k++; end
        end
        a_req = 0; b_req = 0;
        @(posedge clk); #1;
        vectors++;
        if (k !== 4 || order[0] !== 0 || order[1] !== 1 ||
            order[2] !== 0 || order[3] !== 1) begin
            miscompares++;
            $display("FAIL arb order: got %0d acks %0d%0d%0d%0d expected 4 0101",
                     k, order[0], order[1], order[2], order[3]);
        end
        vectors++;
        if (both) begin
            miscompares++;
            $display("FAIL arb simultaneous acks: got 1 expected 0");
        end
        vectors++;
        if (mem[10] !== 37'h0_0000_00aa || mem[11] !== 37'h0_0000_00bb) begin
            miscompares++;
            $display("FAIL arb ram contents: got %h %h expected aa bb",
                     mem[10], mem[11]);
        end
    endtask

    task automatic test_write_read();
        run_txn(0, 1, 8'd5, 37'h1_2345_6789, 2, 0, 0, '0, "a_write5");
        run_txn(0, 0, 8'd5, '0, 3, 0, 1, 37'h1_2345_6789, "a_read5");
        run_txn(1, 0, 8'd5, '0, 3, 0, 1, 37'h1_2345_6789, "b_read5");
    endtask

    task automatic test_out_of_range();
        run_txn(1, 0, 8'd64, '0, 1, 1, 1, 37'h1_2345_6789, "b_read64");
        run_txn(0, 1, 8'd200, 37'h5, 1, 1, 0, '0, "a_write200");
        run_txn(0, 0, 8'd63, '0, 3, 0, 1, 37'h0, "a_read63");
    endtask

    task automatic test_clear();
        int n = 0, clr_cnt = 0, a_at = 0, c_at = 0;
        logic [36:0] rd = '0;
        for (int i = 0; i < 4; i++)
            run_txn(0, 1, 8'(i), 37'h10 + 37'(i), 2, 0, 0, '0, "fill");
        a_req = 1; a_we = 0; a_addr = 8'd2;
        while (c_at == 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) clr_req = 1;
            if (ram_clr) clr_cnt++;
            if (a_ack) begin a_at = n; rd = a_rdata; a_req = 0; end
            if (clr_ack) begin c_at = n; clr_req = 0; end
        end
        a_req = 0; clr_req = 0;
        @(posedge clk); #1;
        vectors++;
        if (a_at !== 3 || rd !== 37'h12) begin
            miscompares++;
            $display("FAIL clr pending read: got ack@%0d data %h expected 3 12",
                     a_at, rd);
        end
        vectors++;
        if (clr_cnt !== 1 || c_at !== 6) begin
            miscompares++;
            $display("FAIL clr pulse: got %0d cycles ack@%0d expected 1 6",
                     clr_cnt, c_at);
        end
        for (int i = 0; i < 4; i++)
            run_txn(0, 0, 8'(i), '0, 3, 0, 1, 37'h0, "after_clr");
    endtask

    task automatic test_reset_midop();
        run_txn(0, 1, 8'd7, 37'h0_dead_beef, 2, 0, 0, '0, "a_write7");
        run_txn(1, 0, 8'd7, '0, 3, 0, 1, 37'h0_dead_beef, "b_read7");
        a_req = 1; a_we = 0; a_addr = 8'd7;
        @(posedge clk); #1;
        vectors++;
        if (ram_re !== 1'b1) begin
            miscompares++;
            $display("FAIL midop in RD0: got ram_re %b expected 1", ram_re);
        end
        rst_n = 0; a_req = 0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 0 || a_ack !== 0 || ram_re !== 0 || b_rdata !== 0 ||
            a_rdata !== 0 || ram_rd_addr !== 0 || ram_wr_data !== 0) begin
            miscompares++;
            $display("FAIL midop reset: got busy=%b ack=%b re=%b brd=%h expected 0",
                     busy, a_ack, ram_re, b_rdata);
        end
        rst_n = 1;
        repeat (2) begin
            @(posedge clk); #1;
            vectors++;
            if (a_ack !== 0 || busy !== 0) begin
                miscompares++;
                $display("FAIL midop stray ack: got ack=%b busy=%b expected 0",
                         a_ack, busy);
            end
        end
        run_txn(0, 0, 8'd7, '0, 3, 0, 1, 37'h0_dead_beef, "a_read7_kept");
    endtask

`ifdef RAM_ARB_WPROT_EN
    task automatic test_wprot();
        run_txn(1, 1, 8'd3, 37'h77, 1, 1, 0, '0, "b_write3_prot");
        run_txn(0, 0, 8'd3, '0, 3, 0, 1, 37'h0, "a_read3_unchanged");
        run_txn(1, 1, 8'd20, 37'h20, 2, 0, 0, '0, "b_write20");
        run_txn(0, 1, 8'd3, 37'h33, 2, 0, 0, '0, "a_write3");
        run_txn(1, 0, 8'd3, '0, 3, 0, 1, 37'h33, "b_read3");
    endtask
`else
    task automatic test_wprot();
        run_txn(1, 1, 8'd3, 37'h77, 2, 0, 0, '0, "b_write3_open");
        run_txn(0, 0, 8'd3, '0, 3, 0, 1, 37'h77, "a_read3");
    endtask
`endif

    initial begin
        test_reset();
        test_arbitration();
        test_write_read();
        test_out_of_range();
        test_clear();
        test_reset_midop();
        test_wprot();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller that sequences the shared 37-bit log RAM (single write port, registered read port with combinational output enable) for clients A and B.
- Serialises single-word read/write transactions with round-robin arbitration and issues the one-cycle RAM clear on request.
- Produces the two-cycle read enable the RAM needs to present registered data, and rejects out-of-range addresses.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 37, RAM word width.
- DEPTH, ADDR_WIDTH**2, number of valid RAM words (64 at default). Addresses >= DEPTH are illegal.
- PROT_TOP, 16, first address client B may write (used only with the optional feature).

Ports:
- clk, in, 1: system clock, all logic on rising edge.
- rst_n, in, 1: synchronous active-low reset.
- a_req, in, 1: client A request, held until a_ack.
- a_we, in, 1: A write (1) / read (0).
- a_addr, in, ADDR_WIDTH: A address.
- a_wdata, in, DATA_WIDTH: A write data.
- a_ack, out, 1: one-cycle completion pulse to A.
- a_err, out, 1: valid with a_ack; request rejected.
- a_rdata, out, DATA_WIDTH: read data, valid with a_ack; held until the next A read completes.
- b_req, b_we, b_addr, b_wdata, b_ack, b_err, b_rdata: client B, identical to A.
- clr_req, in, 1: request to clear the whole RAM, held until clr_ack.
- clr_ack, out, 1: one-cycle pulse when the clear has been issued.
- busy, out, 1: high in any state other than IDLE.
- ram_clr, out, 1: to RAM clr.
- ram_we, out, 1: to RAM we.
- ram_re, out, 1: to RAM re.
- ram_wr_addr, ram_rd_addr, out, ADDR_WIDTH: both driven from the latched address.
- ram_wr_data, out, DATA_WIDTH: latched write data.
- ram_rd_data, in, DATA_WIDTH: from RAM rd_data.

Behaviour:
- Reset (rst_n low at a clock edge):
  - FSM goes to IDLE; last_grant is set to B, so A wins the first tie.
  - All outputs go to 0, including rdata registers and the latched address/data.
  - A transaction in flight is abandoned with no ack.
  - ram_clr is not asserted by reset; RAM contents are untouched.
- FSM states: IDLE, WR, RD0, RD1, CLR, DONE.
- IDLE:
  - Priority order is clr_req > arbitrated client.
  - clr_req -> CLR.
  - Otherwise, if exactly one client requests, grant it. If both request, grant the one that is not last_grant.
  - On grant: latch addr, we, wdata and grant id; update last_grant.
  - addr >= DEPTH (or a protected write, see the optional feature): set the err flag and go to DONE with no RAM access.
  - Legal write -> WR. Legal read -> RD0.
- WR: ram_we=1 for exactly one cycle -> DONE.
- RD0: ram_re=1, ram_we=0; the RAM registers the word -> RD1.
- RD1: ram_re=1, ram_we=0; the RAM output is enabled and ram_rd_data is captured into the granted client's rdata at the end of the cycle -> DONE.
- CLR: ram_clr=1 for one cycle -> DONE. The pending request is the clear, so DONE pulses clr_ack.
- DONE: pulse ack (and err if set) to the granted client, or clr_ack -> IDLE.
- Outside WR/RD0/RD1/CLR: ram_we=ram_re=ram_clr=0.
- Latency, with the request sampled in IDLE at cycle T:
  - write ack at T+2;
  - read ack at T+3;
  - rejected request ack at T+1;
  - clear ack at T+2.
- Client protocol:
  - req must stay high until ack.
  - req sampled high in IDLE after the ack cycle counts as a new transaction.
  - Request fields are sampled only in IDLE; changes while busy are ignored.
- clr_req arriving mid-transaction waits; the current transaction completes, then the clear runs before any pending client.
- A continuously requesting pair alternates A,B,A,B. No client waits more than one transaction plus one clear.

Optional Feature:
- Macro: RAM_ARB_WPROT_EN.
- Defined: a client B write with addr < PROT_TOP is rejected (b_err=1, ack at T+1, no ram_we). B reads and all client A accesses are unaffected.
- Undefined: no protection check; PROT_TOP is unused.

Test Plan:
- Write then read: A writes addr 5 data 37'h1_2345_6789 (ack at T+2, err=0); A reads addr 5 -> a_ack at T+3, a_rdata=37'h1_2345_6789, ram_re high exactly 2 cycles.
- Arbitration: a_req and b_req raised together and held for 4 transactions -> grant order A,B,A,B, one ack per transaction, never simultaneous.
- Out-of-range: B reads addr 64 -> b_ack+b_err at T+1, ram_re never asserted, b_rdata unchanged.
- Clear: fill addr 0..3, assert clr_req during an A read -> read completes correctly, then ram_clr pulses one cycle, clr_ack; subsequent reads of 0..3 return 0.
- Reset mid-op: rst_n low during RD0 -> next cycle busy=0, no ack, ram_re=0, all outputs 0; RAM still holds prior data.
- WPROT (macro defined): B writes addr 3 -> err, RAM unchanged; B writes addr 20 and A writes addr 3 -> both succeed.
